// File: rtl/sort_job_sequencer.sv
// sort_job_sequencer: loads DEPTH items into sorting_top, pulses the sort, streams the sorted RAM back out.
// Latency: load 1 item/cycle; readout 1 item per RD_LAT+2 cycles; all outputs registered.
// Backpressure: out_data/out_last held while out_valid && !out_ready. Define SORT_TIMEOUT_EN for the sort watchdog.
module sort_job_sequencer #(
  parameter int N           = 8,
  parameter int L           = 4,
  parameter int DEPTH       = 8,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic [15:0]  sort_cycles,
  output logic         err,
  output logic         s_rd,
  output logic         s_wrinit,
  output logic [L-1:0] s_raddr,
  output logic [N-1:0] s_datain,
  output logic         s_start,
  input  logic [N-1:0] s_dataout,
  input  logic         s_done
);

  if (DEPTH < 2 || DEPTH > (1 << L) || RD_LAT < 1 || RD_LAT > 4 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("sort_job_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT_DONE, RD_ISSUE, RD_WAIT, OUT_HOLD} state_t;

  localparam logic [L-1:0] IDX_LAST = L'(DEPTH - 1);
  localparam logic [2:0]   LAT_LAST = 3'(RD_LAT - 1);

  state_t       state, state_nxt;
  logic [L-1:0] idx, idx_nxt;
  logic [2:0]   lat_cnt, lat_cnt_nxt;
  logic         in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
  logic [N-1:0] out_data_nxt, s_datain_nxt;
  logic [15:0]  sort_cycles_nxt;
  logic         s_rd_nxt, s_wrinit_nxt, s_start_nxt;
  logic [L-1:0] s_raddr_nxt;
  logic         in_hs, out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

`ifdef SORT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic err_nxt;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    lat_cnt_nxt     = lat_cnt;
    in_ready_nxt    = in_ready;
    out_valid_nxt   = out_valid;
    out_data_nxt    = out_data;
    out_last_nxt    = out_last;
    sort_cycles_nxt = sort_cycles;
    s_rd_nxt        = s_rd;
    s_wrinit_nxt    = 1'b0;
    s_raddr_nxt     = s_raddr;
    s_datain_nxt    = s_datain;
    s_start_nxt     = s_start;
`ifdef SORT_TIMEOUT_EN
    err_nxt         = err;
`endif
    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        if (in_hs) begin
          s_wrinit_nxt = 1'b1;
          s_raddr_nxt  = idx;
          s_datain_nxt = in_data;
          idx_nxt      = idx + 1'b1;
          state_nxt    = LOAD;
`ifdef SORT_TIMEOUT_EN
          err_nxt      = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (in_hs) begin
          s_wrinit_nxt = 1'b1;
          s_raddr_nxt  = idx;
          s_datain_nxt = in_data;
          if (idx == IDX_LAST) begin
            in_ready_nxt = 1'b0;
            idx_nxt      = '0;
            state_nxt    = ARM;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      // A done left high by the previous job must clear before a new start.
      ARM: begin
        if (!s_done) begin
          s_start_nxt     = 1'b1;
          sort_cycles_nxt = '0;
          state_nxt       = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (sort_cycles != 16'hFFFF) sort_cycles_nxt = sort_cycles + 16'd1;
        if (s_done) begin
          s_start_nxt = 1'b0;
          state_nxt   = RD_ISSUE;
        end
`ifdef SORT_TIMEOUT_EN
        else if (sort_cycles == TO_LAST) begin
          s_start_nxt  = 1'b0;
          err_nxt      = 1'b1;
          in_ready_nxt = 1'b1;
          idx_nxt      = '0;
          state_nxt    = IDLE;
        end
`endif
      end
      RD_ISSUE: begin
        s_rd_nxt    = 1'b1;
        s_raddr_nxt = idx;
        lat_cnt_nxt = '0;
        state_nxt   = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          out_data_nxt  = s_dataout;
          out_valid_nxt = 1'b1;
          out_last_nxt  = (idx == IDX_LAST);
          s_rd_nxt      = 1'b0;
          state_nxt     = OUT_HOLD;
        end else begin
          lat_cnt_nxt = lat_cnt + 3'd1;
        end
      end
      OUT_HOLD: begin
        if (out_hs) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
          if (out_last) begin
            idx_nxt      = '0;
            in_ready_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = RD_ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      lat_cnt     <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      sort_cycles <= '0;
      s_rd        <= 1'b0;
      s_wrinit    <= 1'b0;
      s_raddr     <= '0;
      s_datain    <= '0;
      s_start     <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      lat_cnt     <= lat_cnt_nxt;
      in_ready    <= in_ready_nxt;
      out_valid   <= out_valid_nxt;
      out_data    <= out_data_nxt;
      out_last    <= out_last_nxt;
      busy        <= busy_nxt;
      sort_cycles <= sort_cycles_nxt;
      s_rd        <= s_rd_nxt;
      s_wrinit    <= s_wrinit_nxt;
      s_raddr     <= s_raddr_nxt;
      s_datain    <= s_datain_nxt;
      s_start     <= s_start_nxt;
    end
  end

`ifdef SORT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_sort_job_sequencer.sv
// Directed bench for sort_job_sequencer with a behavioural sorting_top model (RAM, sort on done).
module tb_sort_job_sequencer;
  localparam int N = 8, L = 4, DEPTH = 8, RD_LAT = 1, TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, busy, err;
  logic [N-1:0] in_data = '0, out_data, s_datain, s_dataout;
  logic [15:0]  sort_cycles;
  logic         s_rd, s_wrinit, s_start;
  logic         s_done = 1'b0;
  logic [L-1:0] s_raddr;

  int n_cmp = 0, n_err = 0;

  sort_job_sequencer #(.N(N), .L(L), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .sort_cycles(sort_cycles), .err(err),
    .s_rd(s_rd), .s_wrinit(s_wrinit), .s_raddr(s_raddr), .s_datain(s_datain),
    .s_start(s_start), .s_dataout(s_dataout), .s_done(s_done)
  );

  // Sorter model: done 20 cycles after start rises, held done_hold cycles after start falls.
  logic [N-1:0] mem [16];
  logic [N-1:0] srt [16];
  int  model_cnt = 0, model_hold = 0, done_hold = 3;
  bit  never_done = 1'b0;

  always @(posedge clk) if (s_wrinit) mem[s_raddr] <= s_datain;
  assign s_dataout = srt[s_raddr];

  always @(negedge clk) begin : sorter_model
    logic [N-1:0] t;
    if (rst) begin
      model_cnt = 0; model_hold = 0; s_done = 1'b0;
    end else begin
      if (!s_start) model_cnt = 0;
      if (s_start && !s_done) begin
        model_cnt++;
        if (model_cnt == 20 && !never_done) begin
          for (int i = 0; i < DEPTH; i++) srt[i] = mem[i];
          for (int i = 0; i < DEPTH - 1; i++)
            for (int j = 0; j < DEPTH - 1 - i; j++)
              if (srt[j] > srt[j+1]) begin t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t; end
          s_done = 1'b1; model_hold = 0;
        end
      end else if (!s_start && s_done) begin
        model_hold++;
        if (model_hold >= done_hold) s_done = 1'b0;
      end
    end
  end

  logic start_prev = 1'b0, done_at_rise = 1'b0;
  int   start_rises = 0, wr_total = 0;
  always @(negedge clk) begin
    if (s_start && !start_prev) begin start_rises++; done_at_rise = s_done; end
    start_prev = s_start;
    if (s_wrinit) wr_total++;
  end

  task automatic load_job(input logic [7:0] d [8], input bit gaps,
                          output int pulses, output logic [15:0] mask, output bit to);
    int i, cyc; bit hs;
    i = 0; cyc = 0; pulses = 0; mask = '0;
    @(negedge clk);
    while (i < DEPTH && cyc < 200) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_data  = d[i];
      hs = in_valid && in_ready;
      @(negedge clk);
      if (s_wrinit) begin pulses++; mask[s_raddr] = 1'b1; end
      if (hs) i++;
      cyc++;
    end
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    if (s_wrinit) pulses++;
    to = (i < DEPTH);
  endtask

  task automatic collect_job(input int stall_idx, input int stall_n,
                             output logic [7:0] got [8], output logic lst [8], output int n,
                             output logic [7:0] st_dat [5], output logic st_vld [5], output bit to);
    int cyc, sidx; bit fin;
    n = 0; cyc = 0; fin = 1'b0; sidx = stall_idx;
    for (int k = 0; k < 8; k++) begin got[k] = '0; lst[k] = 1'b0; end
    for (int k = 0; k < 5; k++) begin st_dat[k] = '0; st_vld[k] = 1'b0; end
    out_ready = 1'b1;
    while (!fin && cyc < 600) begin
      @(negedge clk); cyc++;
      if (out_valid) begin
        if (n == sidx) begin
          out_ready = 1'b0;
          for (int k = 0; k < stall_n; k++) begin
            st_dat[k] = out_data; st_vld[k] = out_valid;
            @(negedge clk); cyc++;
          end
          sidx = -1;
        end
        out_ready = 1'b1;
        if (n < 8) begin got[n] = out_data; lst[n] = out_last; end
        if (out_last) fin = 1'b1;
        n++;
      end
    end
    to = !fin;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_last, busy, sort_cycles, err,
         s_rd, s_wrinit, s_raddr, s_datain, s_start} !== '0) begin
      n_err++; $display("FAIL reset_outputs: some output nonzero, busy=%0b in_ready=%0b sort_cycles=%0d, required all 0", busy, in_ready, sort_cycles);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL idle_ready: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_sorted_job();
    logic [7:0] d [8], exp [8], got [8], sd [5];
    logic lst [8], sv [5];
    int pulses, n; logic [15:0] mask; bit to_l, to_c;
    d   = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
    exp = '{8'd12, 8'd23, 8'd34, 8'd45, 8'd56, 8'd67, 8'd78, 8'd89};
    load_job(d, 1'b0, pulses, mask, to_l);
    n_cmp++; if (to_l !== 1'b0) begin n_err++; $display("FAIL sorted_load_timeout: timed out=%0b, required 0", to_l); end
    n_cmp++; if (pulses !== 8) begin n_err++; $display("FAIL sorted_wr_pulses: got %0d, required 8", pulses); end
    n_cmp++; if ({busy, in_ready} !== 2'b10) begin n_err++; $display("FAIL sorted_busy_after_load: busy=%0b in_ready=%0b, required 1 0", busy, in_ready); end
    collect_job(-1, 0, got, lst, n, sd, sv, to_c);
    n_cmp++; if (to_c !== 1'b0 || n !== 8) begin n_err++; $display("FAIL sorted_count: items=%0d timeout=%0b, required 8 0", n, to_c); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (got[k] !== exp[k]) begin n_err++; $display("FAIL sorted_data[%0d]: got %0d, required %0d", k, got[k], exp[k]); end
      n_cmp++; if (lst[k] !== (k == 7)) begin n_err++; $display("FAIL sorted_last[%0d]: got %0b, required %0b", k, lst[k], k == 7); end
    end
    @(negedge clk);
    n_cmp++; if ({busy, out_valid} !== 2'b00) begin n_err++; $display("FAIL sorted_idle_after: busy=%0b out_valid=%0b, required 0 0", busy, out_valid); end
    n_cmp++; if (sort_cycles !== 16'd20) begin n_err++; $display("FAIL sorted_sort_cycles: got %0d, required 20", sort_cycles); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL sorted_err: got %0b, required 0", err); end
  endtask

  task automatic test_input_gaps();
    logic [7:0] d [8], exp [8], got [8], sd [5];
    logic lst [8], sv [5];
    int pulses, n; logic [15:0] mask; bit to_l, to_c;
    d   = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
    exp = '{8'd12, 8'd23, 8'd34, 8'd45, 8'd56, 8'd67, 8'd78, 8'd89};
    load_job(d, 1'b1, pulses, mask, to_l);
    n_cmp++; if (to_l !== 1'b0 || pulses !== 8) begin n_err++; $display("FAIL gaps_wr_pulses: got %0d timeout=%0b, required 8 0", pulses, to_l); end
    n_cmp++; if (mask !== 16'h00FF) begin n_err++; $display("FAIL gaps_wr_addrs: got mask %h, required 00ff", mask); end
    collect_job(-1, 0, got, lst, n, sd, sv, to_c);
    n_cmp++; if (to_c !== 1'b0 || n !== 8) begin n_err++; $display("FAIL gaps_count: items=%0d timeout=%0b, required 8 0", n, to_c); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (got[k] !== exp[k]) begin n_err++; $display("FAIL gaps_data[%0d]: got %0d, required %0d", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d [8], exp [8], got [8], sd [5];
    logic lst [8], sv [5];
    int pulses, n, wr0; logic [15:0] mask; bit to_l, to_c;
    d   = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
    exp = '{8'd12, 8'd23, 8'd34, 8'd45, 8'd56, 8'd67, 8'd78, 8'd89};
    load_job(d, 1'b0, pulses, mask, to_l);
    wr0 = wr_total;
    in_valid = 1'b1; in_data = 8'hEE;   // must be ignored while the job is running
    collect_job(2, 5, got, lst, n, sd, sv, to_c);
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    n_cmp++; if (wr_total - wr0 !== 0) begin n_err++; $display("FAIL bp_input_ignored: extra writes %0d, required 0", wr_total - wr0); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({sv[k], sd[k]} !== {1'b1, 8'd34}) begin n_err++; $display("FAIL bp_stall[%0d]: valid=%0b data=%0d, required 1 34", k, sv[k], sd[k]); end
    end
    n_cmp++; if (to_c !== 1'b0 || n !== 8) begin n_err++; $display("FAIL bp_count: items=%0d timeout=%0b, required 8 0", n, to_c); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (got[k] !== exp[k]) begin n_err++; $display("FAIL bp_data[%0d]: got %0d, required %0d", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_back_to_back(input int hold);
    logic [7:0] d [8], d2 [8], exp2 [8], got [8], sd [5];
    logic lst [8], sv [5];
    int pulses, n, r0; logic [15:0] mask; bit to_l, to_c;
    d    = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
    d2   = '{8'd200, 8'd3, 8'd150, 8'd7, 8'd99, 8'd0, 8'd255, 8'd42};
    exp2 = '{8'd0, 8'd3, 8'd7, 8'd42, 8'd99, 8'd150, 8'd200, 8'd255};
    done_hold = hold;
    load_job(d, 1'b0, pulses, mask, to_l);
    collect_job(-1, 0, got, lst, n, sd, sv, to_c);
    n_cmp++; if (sort_cycles !== 16'd20) begin n_err++; $display("FAIL b2b_h%0d_cycles_job1: got %0d, required 20", hold, sort_cycles); end
    r0 = start_rises;
    load_job(d2, 1'b0, pulses, mask, to_l);
    if (hold > 10) begin
      n_cmp++; if (s_done !== 1'b1 || s_start !== 1'b0) begin n_err++; $display("FAIL arm_waits: s_done=%0b s_start=%0b, required 1 0", s_done, s_start); end
    end
    collect_job(-1, 0, got, lst, n, sd, sv, to_c);
    n_cmp++; if (start_rises - r0 !== 1 || done_at_rise !== 1'b0) begin n_err++; $display("FAIL b2b_h%0d_start_rise: rises=%0d done_at_rise=%0b, required 1 0", hold, start_rises - r0, done_at_rise); end
    n_cmp++; if (sort_cycles !== 16'd20) begin n_err++; $display("FAIL b2b_h%0d_cycles_job2: got %0d, required 20", hold, sort_cycles); end
    n_cmp++; if (to_c !== 1'b0 || n !== 8) begin n_err++; $display("FAIL b2b_h%0d_count: items=%0d, required 8", hold, n); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (got[k] !== exp2[k]) begin n_err++; $display("FAIL b2b_h%0d_data[%0d]: got %0d, required %0d", hold, k, got[k], exp2[k]); end
    end
    done_hold = 3;
  endtask

  task automatic test_reset_mid_job();
    logic [7:0] d [8], exp [8], got [8], sd [5];
    logic lst [8], sv [5];
    int pulses, n, cyc; logic [15:0] mask; bit to_l, to_c;
    d   = '{8'd200, 8'd3, 8'd150, 8'd7, 8'd99, 8'd0, 8'd255, 8'd42};
    exp = '{8'd0, 8'd3, 8'd7, 8'd42, 8'd99, 8'd150, 8'd200, 8'd255};
    load_job(d, 1'b0, pulses, mask, to_l);
    cyc = 0;
    while (!s_start && cyc < 50) begin @(negedge clk); cyc++; end
    n_cmp++; if (s_start !== 1'b1) begin n_err++; $display("FAIL midrst_start: s_start=%0b, required 1", s_start); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_last, busy, sort_cycles, err,
         s_rd, s_wrinit, s_raddr, s_datain, s_start} !== '0) begin
      n_err++; $display("FAIL midrst_outputs: busy=%0b s_start=%0b sort_cycles=%0d, required all 0", busy, s_start, sort_cycles);
    end
    rst = 1'b0;
    load_job(d, 1'b0, pulses, mask, to_l);
    collect_job(-1, 0, got, lst, n, sd, sv, to_c);
    n_cmp++; if (to_c !== 1'b0 || n !== 8) begin n_err++; $display("FAIL midrst_count: items=%0d, required 8", n); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (got[k] !== exp[k]) begin n_err++; $display("FAIL midrst_data[%0d]: got %0d, required %0d", k, got[k], exp[k]); end
    end
  endtask

`ifdef SORT_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] d [8];
    int pulses, cyc, high; logic [15:0] mask; bit to_l, saw_valid;
    d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    never_done = 1'b1;
    load_job(d, 1'b0, pulses, mask, to_l);
    cyc = 0; high = 0; saw_valid = 1'b0;
    while (!s_start && cyc < 50) begin @(negedge clk); cyc++; end
    while (s_start && high < 200) begin
      high++; @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    repeat (5) begin @(negedge clk); if (out_valid) saw_valid = 1'b1; end
    n_cmp++; if (high !== 64) begin n_err++; $display("FAIL to_start_width: got %0d cycles, required 64", high); end
    n_cmp++; if ({err, busy, saw_valid} !== 3'b100) begin n_err++; $display("FAIL to_flags: err=%0b busy=%0b out_valid_seen=%0b, required 1 0 0", err, busy, saw_valid); end
    never_done = 1'b0;
    in_valid = 1'b1; in_data = 8'd9;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if ({err, s_wrinit} !== 2'b01) begin n_err++; $display("FAIL to_err_clear: err=%0b s_wrinit=%0b, required 0 1", err, s_wrinit); end
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_sorted_job();
    test_input_gaps();
    test_backpressure();
    test_back_to_back(3);
    test_back_to_back(50);
    test_reset_mid_job();
`ifdef SORT_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench timeout");
  end

endmodule
